sdm_cic_decimator: RTL and testbench
====================================

SDM_CIC_DECIMATOR -- requirements
Module: sdm_cic_decimator

Interface
REQ-001 SHALL provide parameter CH, default 2: number of independent 1-bit SDM channels (1..8).
REQ-002 SHALL provide parameter ORDER, default 4: CIC order N (1..5).
REQ-003 SHALL provide parameter LOG2R, default 6: log2 of decimation ratio R (2..8; R=64 default).
REQ-004 SHALL provide parameter OUT_W, default 16: output sample width, signed (8..ORDER*LOG2R+1).
REQ-005 SHALL have one clock; reset is asynchronous and active-high.
REQ-006 clk  input  1  rising-edge clock for all state.
REQ-007 rst  input  1  asynchronous active-high reset.
REQ-008 clear  input  1  synchronous clear of all filter state, counters and warm-up.
REQ-009 valid_in  input  1  din sample strobe, shared by all channels; any duty, back-to-back allowed.
REQ-010 din  input  CH  one SDM bit per channel; 1 = +1, 0 = -1.
REQ-011 valid_out  output  1  single-cycle strobe, dout/sat valid.
REQ-012 dout  output  CH*OUT_W  signed samples, channel k at bits [k*OUT_W +: OUT_W].
REQ-013 sat  output  CH  per-channel flag, saturation applied to current dout.

Function
REQ-014 Each channel SHALL run an N-stage integrator cascade, decimate by R, then an N-stage comb cascade (differential delay 1).
REQ-015 Integrator/comb arithmetic SHALL be ACC_W = ORDER*LOG2R+2 bits two's complement, wrapping modulo 2^ACC_W (no saturation inside the filter).
REQ-016 Integrators SHALL update only on cycles with valid_in=1; otherwise hold.
REQ-017 A decimation counter SHALL count valid_in cycles 0..R-1, wrapping; the cycle where count=R-1 and valid_in=1 SHALL issue a decimation token.
REQ-018 Comb input SHALL be the last integrator value including the token-cycle sample.
REQ-019 valid_out SHALL be high exactly ORDER+2 clock cycles after the token-producing edge, for one cycle.
REQ-020 Comb stages SHALL advance only when the token reaches them; tokens never overlap since R>=4 cycles apart is guaranteed by R>=4.
REQ-021 Comb result y (range -R^N..+R^N) SHALL be clamped to [-2^(N*LOG2R), 2^(N*LOG2R)-1]; sat[k]=1 when clamping changed channel k.
REQ-022 dout SHALL be the clamped value arithmetically shifted right by N*LOG2R+1-OUT_W (truncation toward -inf).
REQ-023 After reset or clear, the first ORDER tokens SHALL NOT produce valid_out (warm-up); comb state still updates on them.
REQ-024 dout and sat SHALL hold their last value between valid_out strobes.
REQ-025 clear=1 SHALL take priority over valid_in in the same cycle; that sample is discarded and any in-flight token cancelled.
REQ-026 All channels SHALL share counter, token, warm-up and valid_out timing.

Reset
REQ-027 rst=1 SHALL immediately force valid_out=0, dout=0, sat=0, all integrators, combs, counter, token pipeline and warm-up count to 0.
REQ-028 Assertion of rst mid-frame SHALL cancel any in-flight token; after release, the first decimation occurs after R fresh valid_in cycles.
REQ-029 clear SHALL produce the same internal state as rst, except dout/sat hold their values.

Verification (defaults N=4, R=64, OUT_W=16, CH=2; shift 9)
REQ-030 din=2'b11, valid_in=1 continuously -> first valid_out on 5th token (cycle 320+6), dout ch0=ch1=0x7FFF, sat=2'b11 thereafter.
REQ-031 din=2'b00 continuously -> settled dout=0x8000 both channels, sat=2'b00.
REQ-032 ch0 bit pattern 1,0,0,0 repeating (25% density), ch1 alternating 1,0 -> settled ch0=0xC000 (-16384), ch1=0x0000, sat=0.
REQ-033 valid_in duty 50% (every other cycle), din=2'b11 -> valid_out spacing exactly 128 cycles, same values as REQ-030.
REQ-034 rst pulsed at valid_in count 30 mid-operation -> all outputs 0 at once; next valid_out only after 5*64 valid_in following release.
REQ-035 clear and valid_in high in the same cycle at count 63 -> no token, no valid_out from it; dout holds prior value; warm-up restarts.

Source files
------------

// File: rtl/sdm_cic_decimator.sv
// sdm_cic_decimator: multi-channel 1-bit SDM to PCM CIC decimator with clamp and warm-up
module sdm_cic_decimator #(
   parameter int CH    = 2,
   parameter int ORDER = 4,
   parameter int LOG2R = 6,
   parameter int OUT_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                clear,
   input  logic                valid_in,
   input  logic [CH-1:0]       din,
   output logic                valid_out,
   output logic [CH*OUT_W-1:0] dout,
   output logic [CH-1:0]       sat
);
   localparam int NL    = ORDER * LOG2R;
   localparam int ACC_W = NL + 2;
   localparam int SH    = NL + 1 - OUT_W;
   localparam int WW    = $clog2(ORDER + 1);
   typedef logic signed [ACC_W-1:0] acc_t;
   localparam acc_t ONE     = acc_t'(1);
   localparam acc_t POS_LIM = (ONE <<< NL) - ONE;
   localparam acc_t NEG_LIM = -(ONE <<< NL);

   acc_t                int_q [CH][ORDER];
   acc_t                int_d [CH][ORDER];
   acc_t                comb_q[CH][ORDER];
   acc_t                comb_d[CH][ORDER];
   acc_t                dly_q [CH][ORDER];
   acc_t                dly_d [CH][ORDER];
   acc_t                ycl   [CH];
   logic [CH-1:0]       over;
   logic [LOG2R-1:0]    cnt_q, cnt_d;
   logic [ORDER+1:0]    tok_q, tok_d;
   logic [WW-1:0]       warm_q, warm_d;
   logic                valid_q, valid_d;
   logic [CH*OUT_W-1:0] dout_q, dout_d;
   logic [CH-1:0]       sat_q, sat_d;

   // clamp the final comb output to the representable output range and flag clipping
   always_comb begin
      over = '0;
      for (int k = 0; k < CH; k++) begin
         over[k] = comb_q[k][ORDER-1] > POS_LIM || comb_q[k][ORDER-1] < NEG_LIM;
         ycl[k]  = comb_q[k][ORDER-1] > POS_LIM ? POS_LIM :
                   comb_q[k][ORDER-1] < NEG_LIM ? NEG_LIM : comb_q[k][ORDER-1];
      end
   end

   // integrators ripple within one cycle so the token sample is already in the last stage
   always_comb begin
      acc_t acc;
      acc     = '0;
      int_d   = int_q;
      comb_d  = comb_q;
      dly_d   = dly_q;
      cnt_d   = cnt_q;
      tok_d   = tok_q;
      warm_d  = warm_q;
      valid_d = 1'b0;
      dout_d  = dout_q;
      sat_d   = sat_q;
      if (clear) begin
         int_d  = '{default: '0};
         comb_d = '{default: '0};
         dly_d  = '{default: '0};
         cnt_d  = '0;
         tok_d  = '0;
         warm_d = '0;
      end else begin
         tok_d = {tok_q[ORDER:0], valid_in && cnt_q == '1};
         if (valid_in) begin
            cnt_d = cnt_q + 1'b1;
            for (int k = 0; k < CH; k++) begin
               acc = din[k] ? ONE : -ONE;
               for (int j = 0; j < ORDER; j++) begin
                  acc         = acc + int_q[k][j];
                  int_d[k][j] = acc;
               end
            end
         end
         for (int k = 0; k < CH; k++)
            for (int j = 0; j < ORDER; j++)
               if (tok_q[j]) begin
                  acc          = j == 0 ? int_q[k][ORDER-1] : comb_q[k][j-1];
                  comb_d[k][j] = acc - dly_q[k][j];
                  dly_d[k][j]  = acc;
               end
         if (tok_q[ORDER+1]) begin
            if (warm_q == WW'(ORDER)) begin
               valid_d = 1'b1;
               sat_d   = over;
               for (int k = 0; k < CH; k++)
                  dout_d[k*OUT_W +: OUT_W] = OUT_W'(ycl[k] >>> SH);
            end else begin
               warm_d = warm_q + 1'b1;
            end
         end
      end
   end

   // state registers, asynchronously cleared
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         int_q   <= '{default: '0};
         comb_q  <= '{default: '0};
         dly_q   <= '{default: '0};
         cnt_q   <= '0;
         tok_q   <= '0;
         warm_q  <= '0;
         valid_q <= 1'b0;
         dout_q  <= '0;
         sat_q   <= '0;
      end else begin
         int_q   <= int_d;
         comb_q  <= comb_d;
         dly_q   <= dly_d;
         cnt_q   <= cnt_d;
         tok_q   <= tok_d;
         warm_q  <= warm_d;
         valid_q <= valid_d;
         dout_q  <= dout_d;
         sat_q   <= sat_d;
      end
   end

   assign valid_out = valid_q;
   assign dout      = dout_q;
   assign sat       = sat_q;
endmodule

// File: tb/tb_sdm_cic_decimator.sv
// tb_sdm_cic_decimator: random and directed checks against an impulse-response CIC model
module tb_sdm_cic_decimator;
   localparam int CH = 2, ORDER = 4, LOG2R = 6, OUT_W = 16;
   localparam int R = 1 << LOG2R, NL = ORDER * LOG2R, SH = NL + 1 - OUT_W;

   logic                clk = 0, rst = 1, clear = 0, valid_in = 0;
   logic [CH-1:0]       din = '0;
   logic                valid_out;
   logic [CH*OUT_W-1:0] dout;
   logic [CH-1:0]       sat;

   sdm_cic_decimator #(.CH(CH), .ORDER(ORDER), .LOG2R(LOG2R), .OUT_W(OUT_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .valid_in(valid_in), .din(din),
      .valid_out(valid_out), .dout(dout), .sat(sat));

   always #5 clk = ~clk;

   typedef struct {
      int                  due;
      logic [CH*OUT_W-1:0] d;
      logic [CH-1:0]       s;
   } ev_t;

   int                  cyc = 0, n_chk = 0, n_pass = 0;
   logic [CH-1:0]       samp[$];
   longint              h[$];
   ev_t                 pend[$];
   logic [CH*OUT_W-1:0] exp_d = '0;
   logic [CH-1:0]       exp_s = '0;
   logic                exp_v;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      n_chk++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
   endtask

   // impulse response of ((1-z^-R)/(1-z^-1))^N: boxcar of length R convolved N times
   task automatic build_h();
      h.delete();
      h.push_back(1);
      repeat (ORDER) begin
         longint t[$];
         for (int i = 0; i < h.size() + R - 1; i++) begin
            longint s = 0;
            for (int j = 0; j < R; j++)
               if (i - j >= 0 && i - j < h.size()) s += h[i-j];
            t.push_back(s);
         end
         h = t;
      end
   endtask

   function automatic ev_t calc(input int n);
      ev_t e;
      e.due = cyc + ORDER + 2;
      e.d   = '0;
      e.s   = '0;
      for (int k = 0; k < CH; k++) begin
         longint y = 0, yc;
         logic [63:0] t;
         for (int j = 0; j < h.size(); j++)
            if (n - j >= 0) y += samp[n-j][k] ? h[j] : -h[j];
         yc = y > (64'sd1 <<< NL) - 1 ? (64'sd1 <<< NL) - 1 :
              y < -(64'sd1 <<< NL) ? -(64'sd1 <<< NL) : y;
         e.s[k] = yc != y;
         t = yc >>> SH;
         e.d[k*OUT_W +: OUT_W] = t[OUT_W-1:0];
      end
      return e;
   endfunction

   task automatic model_edge();
      int n;
      if (clear) begin
         samp.delete();
         pend.delete();
      end else if (valid_in) begin
         samp.push_back(din);
         n = samp.size() - 1;
         if (n % R == R - 1 && n / R >= ORDER) pend.push_back(calc(n));
      end
   endtask

   task automatic check_out();
      exp_v = 1'b0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
         exp_v = 1'b1;
         exp_d = pend[0].d;
         exp_s = pend[0].s;
         void'(pend.pop_front());
      end
      chk("valid_out", valid_out, exp_v);
      chk("dout", dout, exp_d);
      chk("sat", sat, exp_s);
   endtask

   task automatic step(input logic v, input logic [CH-1:0] d, input logic c = 1'b0);
      valid_in = v;
      din      = d;
      clear    = c;
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check_out();
   endtask

   task automatic do_rst();
      valid_in = 0;
      clear    = 0;
      rst      = 1;
      #1;
      samp.delete();
      pend.delete();
      exp_d = '0;
      exp_s = '0;
      chk("rst_valid_out", valid_out, 1'b0);
      chk("rst_dout", dout, '0);
      chk("rst_sat", sat, '0);
      @(posedge clk);
      cyc++;
      #1;
      rst = 0;
   endtask

   initial begin
      int first, prev, base;
      build_h();
      repeat (3) @(posedge clk);
      #1;
      chk("reset_valid_out", valid_out, 1'b0);
      chk("reset_dout", dout, '0);
      chk("reset_sat", sat, '0);
      rst = 0;

      first = 0;
      for (int i = 0; i < 400; i++) begin
         step(1, 2'b11);
         if (valid_out && first == 0) first = cyc;
      end
      chk("all_ones_first_vo", first, 326);
      chk("all_ones_dout", dout, 32'h7FFF_7FFF);
      chk("all_ones_sat", sat, 2'b11);

      for (int i = 0; i < 500; i++) step(1, 2'b00);
      chk("all_zeros_dout", dout, 32'h8000_8000);
      chk("all_zeros_sat", sat, 2'b00);

      for (int i = 0; i < 600; i++) step(1, {i % 2 == 0, i % 4 == 0});
      chk("density_dout", dout, 32'h0000_C000);
      chk("density_sat", sat, 2'b00);

      prev = 0;
      for (int i = 0; i < 1400; i++) begin
         step(i % 2 == 0, 2'b11);
         if (valid_out) begin
            if (prev != 0) chk("half_duty_spacing", cyc - prev, 128);
            prev = cyc;
         end
      end
      chk("half_duty_dout", dout, 32'h7FFF_7FFF);
      chk("half_duty_sat", sat, 2'b11);

      for (int i = 0; i < 1000 && samp.size() % R != 30; i++)
         step($urandom_range(0, 3) != 0, CH'($urandom));
      chk("rst_at_count30", samp.size() % R, 30);
      do_rst();
      base  = cyc;
      first = 0;
      for (int i = 0; i < 450; i++) begin
         step(1, CH'($urandom));
         if (valid_out && first == 0) first = cyc - base;
      end
      chk("post_rst_first_vo", first, 326);

      for (int i = 0; i < 1000 && samp.size() % R != R - 1; i++)
         step($urandom_range(0, 3) != 0, CH'($urandom));
      chk("clear_at_count63", samp.size() % R, R - 1);
      step(1, CH'($urandom), 1'b1);
      for (int i = 0; i < 1500; i++) step($urandom_range(0, 3) != 0, CH'($urandom));
      for (int i = 0; i < 200; i++) step(1, 2'b01);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
